ofm_tile_addr_gen: RTL and testbench

OFM_TILE_ADDR_GEN -- requirements
Module: ofm_tile_addr_gen

---
 rtl/ofm_tile_addr_gen.sv | 227 ++++++++++++++++++++++
 tb/tb_ofm_tile_addr_gen.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ofm_tile_addr_gen.sv
// rtl/ofm_tile_addr_gen.sv - OFM tile read-address generator.
// Walks column-group-major tiles and emits channel/row/column window addresses.
module ofm_tile_addr_gen #(
  parameter int SYSTOLIC_SIZE = 16,
  parameter int OFM_RAM_SIZE  = 2378675,
  parameter int ADDR_W        = $clog2(OFM_RAM_SIZE)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              clear,
  input  logic [ADDR_W-1:0] start_read_addr,
  input  logic [8:0]        ifm_size,
  input  logic [10:0]       ifm_channel,
  input  logic [2:0]        kernel_size,
  input  logic              stride2,
  input  logic [8:0]        ofm_size,
  input  logic              tile_req,
  input  logic              addr_ready,
  output logic [ADDR_W-1:0] addr,
  output logic              addr_valid,
  output logic [4:0]        tile_w,
  output logic              tile_last,
  output logic              tile_done,
  output logic              done,
  output logic              cfg_err,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, WAIT_TILE, ISSUE, DONE} state_t;

  localparam logic [9:0]        SS10 = 10'(SYSTOLIC_SIZE);
  localparam logic [ADDR_W-1:0] SS_A = ADDR_W'(SYSTOLIC_SIZE);
  localparam logic [ADDR_W-1:0] ONE_A = ADDR_W'(1);

  state_t state;

  // Latched layer configuration
  logic [8:0]        ifm_q;
  logic [10:0]       ch_q;
  logic [2:0]        k_q;
  logic              s2_q;
  logic [8:0]        ofm_q;
  logic [ADDR_W-1:0] plane_q;
  logic [ADDR_W-1:0] row_step_q;

  // Tile position and address pointers
  logic [9:0]        ox0;
  logic [8:0]        oy;
  logic [ADDR_W-1:0] group_base;
  logic [ADDR_W-1:0] tile_origin;
  logic [ADDR_W-1:0] ch_ptr;
  logic [ADDR_W-1:0] row_ptr;
  logic [10:0]       c_cnt;
  logic [2:0]        r_cnt;
  logic [2:0]        col_cnt;

  logic [17:0]       plane_full;
  logic [ADDR_W-1:0] ifm_in_a;
  logic [ADDR_W-1:0] ifm_a;
  logic [ADDR_W-1:0] grp_step;
  logic              cfg_bad;
  logic              accept;
  logic              col_wrap;
  logic              r_wrap;
  logic              oy_wrap;
  logic              more_groups;
  logic              first_last;
  logic [2:0]        col_nx;
  logic [2:0]        r_nx;
  logic [10:0]       c_nx;
  logic              last_nx;
  logic [9:0]        ox0_nx;

  function automatic logic [4:0] calc_tile_w(input logic [8:0] ofm, input logic [9:0] ox);
    logic [9:0] rem;
    rem = {1'b0, ofm} - ox;
    if (rem >= SS10) return 5'(SYSTOLIC_SIZE);
    return rem[4:0];
  endfunction

  assign plane_full  = {9'd0, ifm_size} * {9'd0, ifm_size};
  assign ifm_in_a    = ADDR_W'(ifm_size);
  assign ifm_a       = ADDR_W'(ifm_q);
  assign grp_step    = s2_q ? (SS_A << 1) : SS_A;
  assign cfg_bad     = (kernel_size == 3'd0) || (ifm_channel == 11'd0) || (ofm_size == 9'd0);
  assign accept      = addr_valid && addr_ready;
  assign col_wrap    = (col_cnt == k_q - 3'd1);
  assign r_wrap      = (r_cnt == k_q - 3'd1);
  assign oy_wrap     = (oy == ofm_q - 9'd1);
  assign ox0_nx      = ox0 + SS10;
  assign more_groups = ox0_nx < {1'b0, ofm_q};
  assign first_last  = (ch_q == 11'd1) && (k_q == 3'd1);
  assign busy        = (state != IDLE);

  // Window counter successors; col runs fastest, then row, then channel
  always_comb begin
    col_nx  = col_wrap ? 3'd0 : col_cnt + 3'd1;
    r_nx    = r_cnt;
    c_nx    = c_cnt;
    if (col_wrap) begin
      r_nx = r_wrap ? 3'd0 : r_cnt + 3'd1;
      if (r_wrap) c_nx = c_cnt + 11'd1;
    end
    last_nx = (c_nx == ch_q - 11'd1) && (r_nx == k_q - 3'd1) && (col_nx == k_q - 3'd1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      ifm_q       <= '0;
      ch_q        <= '0;
      k_q         <= '0;
      s2_q        <= 1'b0;
      ofm_q       <= '0;
      plane_q     <= '0;
      row_step_q  <= '0;
      ox0         <= '0;
      oy          <= '0;
      group_base  <= '0;
      tile_origin <= '0;
      ch_ptr      <= '0;
      row_ptr     <= '0;
      c_cnt       <= '0;
      r_cnt       <= '0;
      col_cnt     <= '0;
      addr        <= '0;
      addr_valid  <= 1'b0;
      tile_w      <= '0;
      tile_last   <= 1'b0;
      tile_done   <= 1'b0;
      done        <= 1'b0;
      cfg_err     <= 1'b0;
    end else if (clear) begin
      state      <= IDLE;
      addr_valid <= 1'b0;
      tile_last  <= 1'b0;
      tile_done  <= 1'b0;
      done       <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      tile_done <= 1'b0;
      cfg_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (cfg_bad) begin
              cfg_err <= 1'b1;
            end else begin
              ifm_q       <= ifm_size;
              ch_q        <= ifm_channel;
              k_q         <= kernel_size;
              s2_q        <= stride2;
              ofm_q       <= ofm_size;
              plane_q     <= ADDR_W'(plane_full);
              row_step_q  <= stride2 ? (ifm_in_a << 1) : ifm_in_a;
              ox0         <= '0;
              oy          <= '0;
              group_base  <= start_read_addr;
              tile_origin <= start_read_addr;
              tile_w      <= calc_tile_w(ofm_size, 10'd0);
              state       <= WAIT_TILE;
            end
          end
        end
        WAIT_TILE: begin
          if (tile_req) begin
            addr       <= tile_origin;
            ch_ptr     <= tile_origin;
            row_ptr    <= tile_origin;
            c_cnt      <= '0;
            r_cnt      <= '0;
            col_cnt    <= '0;
            tile_last  <= first_last;
            addr_valid <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          if (accept) begin
            if (tile_last) begin
              addr_valid <= 1'b0;
              tile_last  <= 1'b0;
              tile_done  <= 1'b1;
              if (!oy_wrap) begin
                oy          <= oy + 9'd1;
                tile_origin <= tile_origin + row_step_q;
                state       <= WAIT_TILE;
              end else if (more_groups) begin
                ox0         <= ox0_nx;
                oy          <= '0;
                group_base  <= group_base + grp_step;
                tile_origin <= group_base + grp_step;
                tile_w      <= calc_tile_w(ofm_q, ox0_nx);
                state       <= WAIT_TILE;
              end else begin
                done  <= 1'b1;
                state <= DONE;
              end
            end else begin
              col_cnt   <= col_nx;
              r_cnt     <= r_nx;
              c_cnt     <= c_nx;
              tile_last <= last_nx;
              if (!col_wrap) begin
                addr <= addr + ONE_A;
              end else if (!r_wrap) begin
                row_ptr <= row_ptr + ifm_a;
                addr    <= row_ptr + ifm_a;
              end else begin
                ch_ptr  <= ch_ptr + plane_q;
                row_ptr <= ch_ptr + plane_q;
                addr    <= ch_ptr + plane_q;
              end
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ofm_tile_addr_gen.sv
// tb/tb_ofm_tile_addr_gen.sv - directed self-checking bench for ofm_tile_addr_gen.
module tb_ofm_tile_addr_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, clear, stride2, tile_req, addr_ready;
  logic [21:0] start_read_addr;
  logic [8:0]  ifm_size, ofm_size;
  logic [10:0] ifm_channel;
  logic [2:0]  kernel_size;
  logic [21:0] addr;
  logic        addr_valid, tile_last, tile_done, done, cfg_err, busy;
  logic [4:0]  tile_w;

  int checks = 0;
  int failures = 0;
  int got_addr[$], got_tw[$], got_last[$], stall_addr[$], exp_addr[$], exp_tw[$];
  int n_tile_done, n_done, nv;

  ofm_tile_addr_gen dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
    .start_read_addr(start_read_addr), .ifm_size(ifm_size), .ifm_channel(ifm_channel),
    .kernel_size(kernel_size), .stride2(stride2), .ofm_size(ofm_size),
    .tile_req(tile_req), .addr_ready(addr_ready), .addr(addr), .addr_valid(addr_valid),
    .tile_w(tile_w), .tile_last(tile_last), .tile_done(tile_done), .done(done),
    .cfg_err(cfg_err), .busy(busy)
  );

  task automatic check(input string tag, input longint obs, input longint expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic start_layer(input int base, input int ifm, input int ch, input int k,
                             input int s2v, input int ofm);
    start_read_addr = 22'(base);
    ifm_size        = 9'(ifm);
    ifm_channel     = 11'(ch);
    kernel_size     = 3'(k);
    stride2         = s2v[0];
    ofm_size        = 9'(ofm);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_busy", busy, 1);
    // scramble inputs: the latched configuration must be used
    ifm_size = 9'd2; ifm_channel = 11'd5; kernel_size = 3'd2; ofm_size = 9'd1;
    stride2 = ~stride2; start_read_addr = 22'd7;
  endtask

  task automatic run_layer(input int bp_idx, input int max_cyc);
    int cyc = 0;
    int stall = 0;
    bit new_tile = 1'b1;
    got_addr.delete(); got_tw.delete(); got_last.delete(); stall_addr.delete();
    n_tile_done = 0; n_done = 0;
    while (n_done == 0 && cyc < max_cyc) begin
      if (tile_done) n_tile_done++;
      if (done) n_done++;
      tile_req   = busy && !addr_valid;
      addr_ready = 1'b1;
      if (addr_valid && got_addr.size() == bp_idx && stall < 3) begin
        addr_ready = 1'b0;
        stall++;
        stall_addr.push_back(int'(addr));
      end
      if (addr_valid && addr_ready) begin
        if (new_tile) got_tw.push_back(int'(tile_w));
        new_tile = tile_last;
        if (tile_last) got_last.push_back(got_addr.size());
        got_addr.push_back(int'(addr));
      end
      @(negedge clk);
      cyc++;
    end
    tile_req = 1'b0; addr_ready = 1'b1;
    check("run_timeout", (n_done != 0), 1);
    repeat (3) begin
      if (done) n_done++;
      if (tile_done) n_tile_done++;
      @(negedge clk);
    end
    check("idle_after_done", busy, 0);
  endtask

  task automatic build_exp(input int base, input int ifm, input int ch, input int k,
                           input int s, input int ofm);
    exp_addr.delete(); exp_tw.delete();
    for (int g = 0; g * 16 < ofm; g++)
      for (int oy = 0; oy < ofm; oy++) begin
        exp_tw.push_back((ofm - g * 16) < 16 ? ofm - g * 16 : 16);
        for (int c = 0; c < ch; c++)
          for (int r = 0; r < k; r++)
            for (int col = 0; col < k; col++)
              exp_addr.push_back(base + oy * s * ifm + g * 16 * s + c * ifm * ifm + r * ifm + col);
      end
  endtask

  task automatic compare_seq(input string tag, input int per_tile);
    int bad = 0;
    check({tag, "_len"}, got_addr.size(), exp_addr.size());
    for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++)
      if (got_addr[i] != exp_addr[i]) bad++;
    check({tag, "_seq"}, bad, 0);
    check({tag, "_ntiles"}, got_tw.size(), exp_tw.size());
    bad = 0;
    for (int i = 0; i < got_tw.size() && i < exp_tw.size(); i++)
      if (got_tw[i] != exp_tw[i]) bad++;
    check({tag, "_tile_w"}, bad, 0);
    check({tag, "_nlast"}, got_last.size(), exp_tw.size());
    bad = 0;
    for (int i = 0; i < got_last.size(); i++)
      if (got_last[i] != (i + 1) * per_tile - 1) bad++;
    check({tag, "_last_pos"}, bad, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; clear = 1'b0; stride2 = 1'b0; tile_req = 1'b0;
    addr_ready = 1'b1; start_read_addr = '0; ifm_size = '0; ofm_size = '0;
    ifm_channel = '0; kernel_size = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("rst_addr", addr, 0);
    check("rst_valid", addr_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_tile_w", tile_w, 0);
    check("rst_flags", {tile_last, tile_done, done, cfg_err}, 0);

    // basic 3x3 window, 5x5 plane, 3 tiles
    start_layer(100, 5, 1, 3, 0, 3);
    run_layer(-1, 400);
    check("basic_a0", got_addr[0], 100);
    check("basic_a3", got_addr[3], 105);
    check("basic_a8", got_addr[8], 112);
    check("basic_t1_origin", got_addr[9], 105);
    check("basic_t2_origin", got_addr[18], 110);
    check("basic_tile_w0", got_tw[0], 3);
    check("basic_last0", got_last[0], 8);
    check("basic_tile_done", n_tile_done, 3);
    check("basic_done", n_done, 1);
    build_exp(100, 5, 1, 3, 1, 3);
    compare_seq("basic", 9);

    // same layer with three stall cycles on the fourth address
    start_layer(100, 5, 1, 3, 0, 3);
    run_layer(3, 400);
    check("bp_nstall", stall_addr.size(), 3);
    nv = 0;
    foreach (stall_addr[i]) if (stall_addr[i] != 105) nv++;
    check("bp_hold_addr", nv, 0);
    check("bp_done", n_done, 1);
    compare_seq("bp", 9);

    // 1x1 kernel across three channels
    start_layer(0, 4, 3, 1, 0, 4);
    run_layer(-1, 400);
    check("k1_a0", got_addr[0], 0);
    check("k1_a1", got_addr[1], 16);
    check("k1_a2", got_addr[2], 32);
    check("k1_t1_origin", got_addr[3], 4);
    check("k1_tile_w0", got_tw[0], 4);
    check("k1_tile_done", n_tile_done, 4);
    build_exp(0, 4, 3, 1, 1, 4);
    compare_seq("k1", 3);

    // 18-wide output split into column groups of 16 and 2
    start_layer(0, 20, 1, 3, 0, 18);
    run_layer(-1, 2000);
    check("split_tw_first", got_tw[0], 16);
    check("split_tw_17", got_tw[17], 16);
    check("split_tw_18", got_tw[18], 2);
    check("split_g1_origin", got_addr[18 * 9], 16);
    check("split_tile_done", n_tile_done, 36);
    check("split_done", n_done, 1);
    build_exp(0, 20, 1, 3, 1, 18);
    compare_seq("split", 9);

    // stride 2
    start_layer(0, 7, 1, 3, 1, 3);
    run_layer(-1, 400);
    check("s2_oy1", got_addr[9], 14);
    check("s2_oy2", got_addr[18], 28);
    check("s2_final", got_addr[26], 44);
    check("s2_tile_w0", got_tw[0], 3);
    build_exp(0, 7, 1, 3, 2, 3);
    compare_seq("s2", 9);

    // clear during ISSUE, with tile_req in the same cycle
    start_layer(100, 5, 1, 3, 0, 3);
    tile_req = 1'b1;
    @(negedge clk);
    tile_req = 1'b0;
    check("clr_pre_valid", addr_valid, 1);
    check("clr_first_addr", addr, 100);
    @(negedge clk);
    @(negedge clk);
    check("clr_mid_addr", addr, 102);
    clear = 1'b1; tile_req = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clr_busy", busy, 0);
    check("clr_valid", addr_valid, 0);
    check("clr_last", tile_last, 0);
    n_done = 0; nv = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) n_done++;
      if (addr_valid || busy) nv++;
    end
    tile_req = 1'b0;
    check("clr_no_done", n_done, 0);
    check("clr_idle_quiet", nv, 0);

    // clear wins over a legal start
    start_read_addr = 22'd0; ifm_size = 9'd5; ifm_channel = 11'd1; kernel_size = 3'd3;
    stride2 = 1'b0; ofm_size = 9'd3;
    start = 1'b1; clear = 1'b1;
    @(negedge clk);
    start = 1'b0; clear = 1'b0;
    check("clr_prio_start", busy, 0);

    // illegal configurations
    kernel_size = 3'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("cfg_k0_err", cfg_err, 1);
    check("cfg_k0_busy", busy, 0);
    @(negedge clk);
    check("cfg_k0_pulse", cfg_err, 0);
    check("cfg_k0_busy2", busy, 0);
    kernel_size = 3'd3; ifm_channel = 11'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("cfg_ch0_err", cfg_err, 1);
    check("cfg_ch0_busy", busy, 0);
    ifm_channel = 11'd1; ofm_size = 9'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("cfg_ofm0_err", cfg_err, 1);
    @(negedge clk);

    // reset mid-tile
    start_layer(100, 5, 1, 3, 0, 3);
    tile_req = 1'b1;
    @(negedge clk);
    tile_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mrst_valid", addr_valid, 0);
    check("mrst_busy", busy, 0);
    check("mrst_addr", addr, 0);
    check("mrst_tile_w", tile_w, 0);
    tile_req = 1'b1; nv = 0;
    repeat (5) begin
      @(negedge clk);
      if (addr_valid || busy) nv++;
    end
    tile_req = 1'b0;
    check("mrst_quiet", nv, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
